// File: rtl/div_radix2_pkg.sv
// Shared definitions for the radix-2 restoring divider: FSM encoding,
// default iteration count and small two's-complement helpers.
package div_radix2_pkg;

    localparam int DIV_CYCLES_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Two's-complement negation of a 32-bit word.
    function automatic logic [31:0] neg32(input logic [31:0] v);
        return (~v) + 32'd1;
    endfunction

    // Magnitude of v when treated as signed; identity when unsigned.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
        logic [31:0] r;
        if (is_signed && v[31]) begin
            r = neg32(v);
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/div_radix2_if.sv
// Pipeline-side handshake of the divider: start/operands in, stall/result out.
interface div_radix2_if;

    logic        startE;
    logic        signed_divE;
    logic [31:0] a;
    logic [31:0] b;
    logic        pipe_stall;
    logic        cancel;
    logic        div_stallE;
    logic [63:0] result;
    logic        result_valid;

    // Pipeline / stimulus side.
    modport master (
        output startE, signed_divE, a, b, pipe_stall, cancel,
        input  div_stallE, result, result_valid
    );

    // Divider side.
    modport slave (
        input  startE, signed_divE, a, b, pipe_stall, cancel,
        output div_stallE, result, result_valid
    );

endinterface

// File: rtl/div_radix2_step.sv
// One restoring shift-subtract step: shift the next dividend bit (MSB of
// quot_i) into the partial remainder, subtract the divisor if it fits and
// shift the resulting quotient bit into the LSB.
module div_step (
    input  logic [31:0] rem_i,
    input  logic [31:0] quot_i,
    input  logic [31:0] divisor_i,
    output logic [31:0] rem_o,
    output logic [31:0] quot_o
);

    logic [32:0] shifted_s;
    logic [32:0] diff_s;

    // Trial subtraction; bit 32 of the difference is the borrow.
    always_comb begin
        shifted_s = {rem_i, quot_i[31]};
        diff_s    = shifted_s - {1'b0, divisor_i};
        if (diff_s[32] == 1'b0) begin
            rem_o  = diff_s[31:0];
            quot_o = {quot_i[30:0], 1'b1};
        end else begin
            rem_o  = shifted_s[31:0];
            quot_o = {quot_i[30:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_radix2.sv
// Iterative radix-2 restoring divider for DIV/DIVU. Operands are latched as
// magnitudes in the start cycle, one quotient bit is produced per BUSY cycle
// and the sign-corrected {remainder, quotient} is held in DONE until the
// pipeline advances.
module div_radix2
    import div_radix2_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    div_radix2_if.slave   bus
);

    localparam int CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

    div_state_e  state_q,        state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [31:0] rem_q,          rem_d;
    logic [31:0] quot_q,         quot_d;
    logic [31:0] divisor_q,      divisor_d;
    logic        q_sign_q,       q_sign_d;
    logic        r_sign_q,       r_sign_d;
    logic        dz_q,           dz_d;
    logic [63:0] result_q,       result_d;
    logic        result_valid_q, result_valid_d;

    logic [31:0] step_rem_s;
    logic [31:0] step_quot_s;
    logic [31:0] lo_s;
    logic [31:0] hi_s;

    div_step u_step (
        .rem_i     (rem_q),
        .quot_i    (quot_q),
        .divisor_i (divisor_q),
        .rem_o     (step_rem_s),
        .quot_o    (step_quot_s)
    );

    // Sign correction of the final step; a zero divisor forces an all-ones
    // quotient, while the remainder naturally comes back as the dividend.
    always_comb begin
        if (dz_q) begin
            lo_s = 32'hFFFF_FFFF;
        end else if (q_sign_q) begin
            lo_s = neg32(step_quot_s);
        end else begin
            lo_s = step_quot_s;
        end
        if (r_sign_q) begin
            hi_s = neg32(step_rem_s);
        end else begin
            hi_s = step_rem_s;
        end
    end

    // Next-state and datapath update; cancel wins over everything.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quot_d    = quot_q;
        divisor_d = divisor_q;
        q_sign_d  = q_sign_q;
        r_sign_d  = r_sign_q;
        dz_d      = dz_q;
        result_d  = result_q;
        if (bus.cancel) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.startE) begin
                        rem_d     = 32'd0;
                        quot_d    = abs32(bus.a, bus.signed_divE);
                        divisor_d = abs32(bus.b, bus.signed_divE);
                        q_sign_d  = bus.signed_divE & (bus.a[31] ^ bus.b[31]);
                        r_sign_d  = bus.signed_divE & bus.a[31];
                        dz_d      = (bus.b == 32'd0);
                        cnt_d     = {CNT_W{1'b0}};
                        state_d   = BUSY;
                    end else begin
                        state_d = IDLE;
                    end
                end
                BUSY: begin
                    rem_d  = step_rem_s;
                    quot_d = step_quot_s;
                    cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_q == CNT_W'(DIV_CYCLES - 1)) begin
                        result_d = {hi_s, lo_s};
                        state_d  = DONE;
                    end else begin
                        state_d = BUSY;
                    end
                end
                DONE: begin
                    if (!bus.pipe_stall) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        result_valid_d = (state_d == DONE);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= {CNT_W{1'b0}};
            rem_q          <= 32'd0;
            quot_q         <= 32'd0;
            divisor_q      <= 32'd0;
            q_sign_q       <= 1'b0;
            r_sign_q       <= 1'b0;
            dz_q           <= 1'b0;
            result_q       <= 64'd0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            rem_q          <= rem_d;
            quot_q         <= quot_d;
            divisor_q      <= divisor_d;
            q_sign_q       <= q_sign_d;
            r_sign_q       <= r_sign_d;
            dz_q           <= dz_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    // The stall must rise in the start cycle itself, so it is combinational.
    assign bus.div_stallE   = ~rst & ~bus.cancel &
                              ((bus.startE & (state_q == IDLE)) | (state_q == BUSY));
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;

endmodule

// File: tb/tb_div_radix2.sv
// Directed bench for div_radix2: latency, signed/unsigned results, divide by
// zero, overflow case, pipe_stall hold in DONE, cancel and reset aborts.
module tb_div_radix2;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    div_radix2_if ifc ();

    div_radix2 #(.DIV_CYCLES(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        ifc.startE = 1'b1;
        ifc.signed_divE = 1'b0;
        ifc.a = 32'd100;
        ifc.b = 32'd7;
        ifc.pipe_stall = 1'b0;
        ifc.cancel = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks++;
            if (ifc.div_stallE !== 1'b0) begin
                failures++;
                $display("FAIL reset_stall got=%b exp=0", ifc.div_stallE);
            end
            checks++;
            if (ifc.result_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_valid got=%b exp=0", ifc.result_valid);
            end
        end
        ifc.startE = 1'b0;
        rst = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (ifc.div_stallE !== 1'b0 || ifc.result_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle got stall=%b valid=%b exp 0/0", ifc.div_stallE, ifc.result_valid);
        end
    endtask

    // Full division with pipe_stall low: 33 stall cycles, one DONE cycle.
    task automatic run_div(input logic [31:0] ta, input logic [31:0] tbv, input logic sgn,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi, input string nm);
        int stall_cnt;
        @(negedge clk);
        ifc.startE = 1'b1;
        ifc.signed_divE = sgn;
        ifc.a = ta;
        ifc.b = tbv;
        stall_cnt = 0;
        #1;
        while (ifc.div_stallE === 1'b1 && stall_cnt < 100) begin
            stall_cnt++;
            @(negedge clk); #1;
        end
        checks++;
        if (stall_cnt != 33) begin
            failures++;
            $display("FAIL %s_latency got=%0d exp=33", nm, stall_cnt);
        end
        checks++;
        if (ifc.result_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s_valid got=%b exp=1", nm, ifc.result_valid);
        end
        checks++;
        if (ifc.result !== {exp_hi, exp_lo}) begin
            failures++;
            $display("FAIL %s_result got=%h exp=%h", nm, ifc.result, {exp_hi, exp_lo});
        end
        @(negedge clk);
        ifc.startE = 1'b0;
        #1;
        checks++;
        if (ifc.result_valid !== 1'b0 || ifc.div_stallE !== 1'b0) begin
            failures++;
            $display("FAIL %s_after got valid=%b stall=%b exp 0/0", nm, ifc.result_valid, ifc.div_stallE);
        end
    endtask

    task automatic test_unsigned();
        run_div(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, "divu_100_7");
        run_div(32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, "divu_big");
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, "divu_small_q");
    endtask

    task automatic test_signed();
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "div_m7_2");
        run_div(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, "div_7_m2");
        run_div(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 32'd3, 32'hFFFF_FFFF, "div_m7_m2");
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, "div_ovf");
    endtask

    task automatic test_div_zero();
        run_div(32'h0000_1234, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h0000_1234, "dz_signed");
        run_div(32'hFFFF_FFF9, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9, "dz_neg");
        run_div(32'hFFFF_FFFF, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "dz_unsigned");
    endtask

    // pipe_stall high throughout: iteration not paused, DONE held 5 cycles.
    task automatic test_pipe_stall_hold();
        int stall_cnt;
        @(negedge clk);
        ifc.startE = 1'b1;
        ifc.signed_divE = 1'b0;
        ifc.a = 32'd100;
        ifc.b = 32'd7;
        ifc.pipe_stall = 1'b1;
        stall_cnt = 0;
        #1;
        while (ifc.div_stallE === 1'b1 && stall_cnt < 100) begin
            stall_cnt++;
            @(negedge clk); #1;
        end
        checks++;
        if (stall_cnt != 33) begin
            failures++;
            $display("FAIL hold_latency got=%0d exp=33", stall_cnt);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (ifc.result_valid !== 1'b1 || ifc.div_stallE !== 1'b0 ||
                ifc.result !== {32'd2, 32'd14}) begin
                failures++;
                $display("FAIL hold_cycle%0d got valid=%b stall=%b result=%h exp 1/0/%h",
                         i, ifc.result_valid, ifc.div_stallE, ifc.result, {32'd2, 32'd14});
            end
            @(negedge clk); #1;
        end
        ifc.pipe_stall = 1'b0;
        ifc.startE = 1'b0;
        #1;
        checks++;
        if (ifc.result_valid !== 1'b1) begin
            failures++;
            $display("FAIL hold_last got valid=%b exp=1", ifc.result_valid);
        end
        @(negedge clk); #1;
        checks++;
        if (ifc.result_valid !== 1'b0 || ifc.div_stallE !== 1'b0) begin
            failures++;
            $display("FAIL hold_release got valid=%b stall=%b exp 0/0", ifc.result_valid, ifc.div_stallE);
        end
    endtask

    // Cancel mid-BUSY, and cancel together with start in IDLE.
    task automatic test_cancel();
        int bad;
        @(negedge clk);
        ifc.startE = 1'b1;
        ifc.signed_divE = 1'b0;
        ifc.a = 32'd100;
        ifc.b = 32'd7;
        repeat (11) @(negedge clk);
        ifc.cancel = 1'b1;
        #1;
        checks++;
        if (ifc.div_stallE !== 1'b0) begin
            failures++;
            $display("FAIL cancel_stall got=%b exp=0", ifc.div_stallE);
        end
        @(negedge clk);
        ifc.cancel = 1'b0;
        ifc.startE = 1'b0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (ifc.result_valid !== 1'b0 || ifc.div_stallE !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL cancel_idle got %0d busy/valid cycles exp=0", bad);
        end
        ifc.startE = 1'b1;
        ifc.cancel = 1'b1;
        #1;
        checks++;
        if (ifc.div_stallE !== 1'b0) begin
            failures++;
            $display("FAIL cancel_start_stall got=%b exp=0", ifc.div_stallE);
        end
        @(negedge clk);
        ifc.startE = 1'b0;
        ifc.cancel = 1'b0;
        #1;
        checks++;
        if (ifc.div_stallE !== 1'b0) begin
            failures++;
            $display("FAIL cancel_start_nostart got=%b exp=0", ifc.div_stallE);
        end
    endtask

    // Reset pulsed mid-BUSY, then a fresh division.
    task automatic test_reset_busy();
        @(negedge clk);
        ifc.startE = 1'b1;
        ifc.signed_divE = 1'b1;
        ifc.a = 32'hFFFF_FFF9;
        ifc.b = 32'd2;
        repeat (12) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (ifc.div_stallE !== 1'b0 || ifc.result_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_busy got stall=%b valid=%b exp 0/0", ifc.div_stallE, ifc.result_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        ifc.startE = 1'b0;
        #1;
        checks++;
        if (ifc.div_stallE !== 1'b0) begin
            failures++;
            $display("FAIL rst_release_idle got=%b exp=0", ifc.div_stallE);
        end
        run_div(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, "after_rst");
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_pipe_stall_hold();
        test_cancel();
        test_reset_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
